// File: rtl/sorted_ram_streamer.sv
// rtl/sorted_ram_streamer.sv - streams sorter RAM contents 0..last_addr on a valid/ready port
//
// Purpose: after a sort completes, reads the RAM from address 0 up to a
// latched last address and streams each element out, flagging any element
// that is smaller than the one transferred before it.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_start, i_last_addr  run request (taken only when idle) and last index
//   o_rd_en, o_rd_addr    RAM read strobe and address
//   i_rd_data             RAM data, valid the cycle after o_rd_en
//   o_valid, o_data,
//   o_last, i_ready       output element stream
//   o_busy, o_done        run in progress / one-cycle completion pulse
//   o_order_err           sticky non-decreasing order violation
module sorted_ram_streamer #(
  parameter int SIZE_ADDR = 4,
  parameter int SIZE_DATA = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [SIZE_ADDR-1:0] i_last_addr,
  output logic                 o_rd_en,
  output logic [SIZE_ADDR-1:0] o_rd_addr,
  input  logic [SIZE_DATA-1:0] i_rd_data,
  output logic                 o_valid,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_last,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_order_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [SIZE_ADDR-1:0] ADDR_ONE = 1;

  logic [1:0]           state;
  logic [SIZE_ADDR-1:0] last_addr;
  logic [SIZE_ADDR-1:0] rd_ptr;
  // inflight marks that the RAM is presenting data for last cycle's read
  logic                 inflight;
  logic                 inflight_last;

  logic [SIZE_DATA-1:0] fifo_data [2];
  logic                 fifo_last [2];
  logic                 wr_sel;
  logic                 rd_sel;
  logic [1:0]           count;

  logic [SIZE_DATA-1:0] prev_data;
  logic                 have_prev;
  logic                 order_err;

  logic                 pop;
  logic                 push;
  logic [2:0]           occ;
  logic                 rd_issue;
  logic                 at_last;
  logic                 drain_done;

  assign o_valid = (count != 2'd0);
  assign pop     = o_valid && i_ready;
  assign push    = inflight;

  // Occupancy the FIFO will see once this cycle's pop and the pending
  // capture settle; a new read is allowed only while that leaves a slot.
  assign occ      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign rd_issue = (state == S_READ) && (occ < 3'd2);
  assign at_last  = (rd_ptr == last_addr);

  // The final transfer may happen on the very edge that leaves DRAIN.
  assign drain_done = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop));

  assign o_rd_en     = rd_issue;
  assign o_rd_addr   = rd_ptr;
  assign o_data      = fifo_data[rd_sel];
  assign o_last      = o_valid && fifo_last[rd_sel];
  assign o_busy      = (state != S_IDLE);
  assign o_done      = (state == S_DONE);
  assign o_order_err = order_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      last_addr <= '0;
      rd_ptr    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            last_addr <= i_last_addr;
            rd_ptr    <= '0;
            state     <= S_READ;
          end
        end
        S_READ: begin
          if (rd_issue) begin
            rd_ptr <= rd_ptr + ADDR_ONE;
            if (at_last) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Read pipeline and 2-entry FIFO; the last tag rides with its read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last[0]  <= 1'b0;
      fifo_last[1]  <= 1'b0;
      wr_sel        <= 1'b0;
      rd_sel        <= 1'b0;
      count         <= 2'd0;
    end else begin
      inflight      <= rd_issue;
      inflight_last <= rd_issue && at_last;
      if (push) begin
        fifo_data[wr_sel] <= i_rd_data;
        fifo_last[wr_sel] <= inflight_last;
        wr_sel            <= ~wr_sel;
      end
      if (pop) begin
        rd_sel <= ~rd_sel;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Order check over transferred elements; the first of a run has no
  // predecessor and is never flagged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_data <= '0;
      have_prev <= 1'b0;
      order_err <= 1'b0;
    end else if ((state == S_IDLE) && i_start) begin
      have_prev <= 1'b0;
      order_err <= 1'b0;
    end else if (pop) begin
      if (have_prev && (o_data < prev_data)) begin
        order_err <= 1'b1;
      end
      prev_data <= o_data;
      have_prev <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sorted_ram_streamer.sv
// tb/tb_sorted_ram_streamer.sv - self-checking bench for sorted_ram_streamer
module tb_sorted_ram_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] last_addr;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       ready;
  logic       busy;
  logic       done;
  logic       order_err;

  int checks = 0;
  int failures = 0;

  sorted_ram_streamer #(.SIZE_ADDR(4), .SIZE_DATA(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_last_addr(last_addr),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_valid(valid), .o_data(data), .o_last(last), .i_ready(ready),
    .o_busy(busy), .o_done(done), .o_order_err(order_err)
  );

  always #5 clk = ~clk;

  // RAM model: data for a read appears the cycle after the strobe
  logic [7:0] ram [16];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records what the stream and read port did, sampled mid-cycle
  int         xfer_data [$];
  int         xfer_last [$];
  int         xfer_edge [$];
  int         xfer_err  [$];
  int         rd_addrs  [$];
  int         done_cyc  [$];
  int         done_err  [$];
  int         valid_cycles = 0;
  int         stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (valid && ready) begin
      xfer_data.push_back(int'(data));
      xfer_last.push_back(int'(last));
      xfer_edge.push_back(cyc + 1);
      xfer_err.push_back(int'(order_err));
    end
    if (rd_en) rd_addrs.push_back(int'(rd_addr));
    if (done) begin
      done_cyc.push_back(cyc);
      done_err.push_back(int'(order_err));
    end
    if (valid) valid_cycles <= valid_cycles + 1;
    if (prev_stall && valid && (data !== prev_data)) stall_viol <= stall_viol + 1;
    prev_stall <= valid && !ready;
    prev_data  <= data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick_ready(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // One full run: mode 0 = ready always, 1 = toggling, 2 = random.
  task automatic run(input int la, input int mode, input bit poke);
    int n, e, x0, a0, d0, sv0, inv;
    int a [16];
    n   = la + 1;
    for (int i = 0; i < 16; i++) a[i] = int'(ram[i]);
    x0  = xfer_data.size();
    a0  = rd_addrs.size();
    d0  = done_cyc.size();
    sv0 = stall_viol;
    @(posedge clk); #1;
    last_addr = 4'(la);
    start = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    start = 1'b0;
    last_addr = 4'($urandom);
    chk("busy_at_start", 32'(busy), 32'd1);
    chk("rd_en_at_start", 32'(rd_en), 32'd1);
    chk("rd_addr_at_start", 32'(rd_addr), 32'd0);
    chk("err_cleared", 32'(order_err), 32'd0);
    for (int k = 0; k < 400 && done_cyc.size() == d0; k++) begin
      ready = pick_ready(mode, k);
      start = poke && (k == 2);
      @(posedge clk); #1;
    end
    start = 1'b0;
    ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("done_count", 32'(done_cyc.size() - d0), 32'd1);
    chk("rd_count", 32'(rd_addrs.size() - a0), 32'(n));
    for (int k = 0; k < n; k++)
      if (a0 + k < rd_addrs.size()) chk("rd_addr_seq", 32'(rd_addrs[a0 + k]), 32'(k));
    chk("xfer_count", 32'(xfer_data.size() - x0), 32'(n));
    inv = 0;
    for (int k = 0; k < n; k++) begin
      if (x0 + k < xfer_data.size()) begin
        chk("xfer_data", 32'(xfer_data[x0 + k]), 32'(a[k]));
        chk("xfer_last", 32'(xfer_last[x0 + k]), 32'(k == la));
        chk("err_before_xfer", 32'(xfer_err[x0 + k]), 32'(inv));
      end
      if (k >= 1 && a[k] < a[k - 1]) inv = 1;
    end
    if (done_cyc.size() > d0) begin
      chk("err_at_done", 32'(done_err[d0]), 32'(inv));
      if (mode == 0) chk("done_cycle", 32'(done_cyc[d0]), 32'(e + 2 + n));
    end
    if (mode == 0 && xfer_data.size() > x0) begin
      chk("first_xfer_edge", 32'(xfer_edge[x0]), 32'(e + 3));
      chk("last_xfer_edge", 32'(xfer_edge[xfer_edge.size() - 1]), 32'(e + 2 + n));
    end
    chk("err_sticky_idle", 32'(order_err), 32'(inv));
    chk("busy_idle", 32'(busy), 32'd0);
    chk("stall_stable", 32'(stall_viol - sv0), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_last"}, 32'(last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(order_err), 32'd0);
  endtask

  initial begin
    int vc0, d0, sz;
    logic [7:0] v;
    rst = 1'b1;
    start = 1'b0;
    last_addr = 4'd0;
    ready = 1'b1;
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;

    // ascending full RAM, continuous and toggling ready
    run(15, 0, 1'b0);
    run(15, 1, 1'b0);

    // single element
    ram[0] = 8'h5A;
    run(0, 0, 1'b0);

    // one inversion, then a clean run must clear the flag
    ram[0] = 8'h01; ram[1] = 8'h03; ram[2] = 8'h02; ram[3] = 8'h04;
    run(3, 0, 1'b0);
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    run(15, 2, 1'b0);

    // start pulse during READ is ignored
    run(15, 0, 1'b1);

    // random contents and lengths, some sorted, some not
    for (int t = 0; t < 6; t++) begin
      sz = int'($urandom_range(0, 15));
      v = 8'($urandom_range(0, 40));
      for (int i = 0; i < 16; i++) begin
        if (t % 2 == 0) begin
          v = v + 8'($urandom_range(0, 12));
          ram[i] = v;
        end else begin
          ram[i] = 8'($urandom);
        end
      end
      run(sz, 2, 1'b0);
    end

    // reset while the stream is stalled
    for (int i = 0; i < 16; i++) ram[i] = 8'($urandom_range(1, 255));
    @(posedge clk); #1;
    last_addr = 4'd7;
    start = 1'b1;
    ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("stalled_valid", 32'(valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    vc0 = valid_cycles;
    d0 = done_cyc.size();
    ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_valid_after_rst", 32'(valid_cycles - vc0), 32'd0);
    chk("no_done_after_rst", 32'(done_cyc.size() - d0), 32'd0);
    for (int i = 0; i < 16; i++) ram[i] = 8'(i * 3);
    run(9, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
